add_order_encoder: RTL

//  Serialising ITCH Add Order encoder: accepts one parallel Add Order record per handshake and emits it as a
//  26-byte big-endian byte stream with start/end framing, plus a length side-band for the length validator.

---
 rtl/itch_pkg.sv | 64 ++++++
 rtl/itch_byte_serializer.sv | 69 ++++++
 rtl/add_order_encoder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/itch_pkg.sv
// Shared ITCH definitions: message constants, Add Order byte offsets, the
// encoder FSM state type, the parallel Add Order record and its byte mux.
package itch_pkg;

  // Message type and side codes (ASCII)
  localparam logic [7:0] ITCH_TYPE_ADD = 8'h41;  // 'A'
  localparam logic [7:0] ITCH_BUY      = 8'h42;  // 'B'
  localparam logic [7:0] ITCH_SELL     = 8'h53;  // 'S'

  // Add Order length in bytes, type byte included
  localparam int ADD_ORDER_LEN = 26;

  // Byte offset of the first (most significant) byte of each field
  localparam int OFS_ORDER_REF = 1;
  localparam int OFS_SIDE      = 9;
  localparam int OFS_SHARES    = 10;
  localparam int OFS_STOCK     = 14;
  localparam int OFS_PRICE     = 22;

  // Byte index width; covers message lengths up to 63 bytes
  localparam int IDX_W = 6;

  // Encoder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } enc_state_t;

  // Parallel Add Order record as captured from the input port
  typedef struct packed {
    logic [63:0] order_ref;
    logic        buy_sell;
    logic [31:0] shares;
    logic [63:0] stock_symbol;
    logic [31:0] price;
  } add_order_t;

  // Big-endian byte mux: returns byte 'idx' of the serialised Add Order.
  // Any index past the Add Order body reads as 0x00, which pads messages
  // configured longer than the standard 26 bytes.
  function automatic logic [7:0] add_order_byte(input add_order_t       rec,
                                                input logic [IDX_W-1:0] idx);
    int         i;
    logic [7:0] b;
    i = int'(idx);
    b = 8'h00;
    if (i == 0) begin
      b = ITCH_TYPE_ADD;
    end else if (i < OFS_SIDE) begin
      b = rec.order_ref[8*(OFS_SIDE-1-i) +: 8];
    end else if (i == OFS_SIDE) begin
      b = rec.buy_sell ? ITCH_BUY : ITCH_SELL;
    end else if (i < OFS_STOCK) begin
      b = rec.shares[8*(OFS_STOCK-1-i) +: 8];
    end else if (i < OFS_PRICE) begin
      b = rec.stock_symbol[8*(OFS_PRICE-1-i) +: 8];
    end else if (i < ADD_ORDER_LEN) begin
      b = rec.price[8*(ADD_ORDER_LEN-1-i) +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/itch_byte_serializer.sv
// Generic byte-index sequencer for a fixed-length frame on a ready/valid
// stream. It owns the valid bit, the current byte index and the start/end
// flags; the instantiating block owns the data register and reloads it
// whenever 'load' is high, using 'load_idx' to select the next byte.
//
// Handshake: a byte transfers on a rising edge where valid && ready_in.
// Once valid is raised it stays high until the last byte transfers, and
// while ready_in is low the index and both flags hold, so the presented
// byte and its framing stay stable for the whole stall.
module itch_byte_serializer #(
  parameter int LEN   = 26,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ready_in,
  output logic             valid,
  output logic             start_flag,
  output logic             end_flag,
  output logic             load,
  output logic [IDX_W-1:0] load_idx,
  output logic             last_xfer
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  logic [IDX_W-1:0] idx;
  logic             xfer;
  logic             at_last;
  logic             begin_frame;

  assign xfer        = valid && ready_in;
  assign at_last     = (idx == LAST_IDX);
  assign last_xfer   = xfer && at_last;
  // A new frame can only begin once the previous one has fully drained.
  assign begin_frame = start && !valid;
  // The data register must be refilled when a frame begins and after every
  // accepted byte except the final one.
  assign load        = begin_frame || (xfer && !at_last);
  assign load_idx    = valid ? (idx + 1'b1) : '0;

  // Index, valid and framing flags; everything holds while ready_in is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      idx        <= '0;
      start_flag <= 1'b0;
      end_flag   <= 1'b0;
    end else if (begin_frame) begin
      valid      <= 1'b1;
      idx        <= '0;
      start_flag <= 1'b1;
      end_flag   <= 1'b0;
    end else if (xfer) begin
      if (at_last) begin
        valid      <= 1'b0;
        idx        <= '0;
        start_flag <= 1'b0;
        end_flag   <= 1'b0;
      end else begin
        idx        <= idx + 1'b1;
        start_flag <= 1'b0;
        end_flag   <= ((idx + 1'b1) == LAST_IDX);
      end
    end
  end

endmodule

// File: rtl/add_order_encoder.sv
// Serialising ITCH Add Order encoder. One parallel record is accepted per
// enc_valid/enc_ready handshake and sent as a MSG_LEN-byte big-endian
// stream with start/end framing and a length side-band on byte 0.
//
// Input handshake: a record is taken on a rising edge where
// enc_valid && enc_ready; enc_ready is high only in IDLE, so enc_valid in
// any other state is ignored. Output handshake: a byte transfers on a rising
// edge where payload_valid_out && payload_ready_in; while payload_ready_in
// is low, data, flags and length side-band hold.
module add_order_encoder
  import itch_pkg::*;
#(
  parameter int MSG_LEN = ADD_ORDER_LEN,
  parameter int GAP_CYC = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_valid,
  output logic             enc_ready,
  input  logic [63:0]      order_ref,
  input  logic             buy_sell,
  input  logic [31:0]      shares,
  input  logic [63:0]      stock_symbol,
  input  logic [31:0]      price,
  output logic [7:0]       payload_out,
  output logic             payload_valid_out,
  input  logic             payload_ready_in,
  output logic             start_flag_out,
  output logic             end_flag_out,
  output logic [5:0]       expected_length_out,
  output logic             length_valid_out,
  output logic [CNT_W-1:0] msg_count
);

  // Last cycle of the inter-message gap; unused when GAP_CYC is 0
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  enc_state_t       state;
  add_order_t       held;
  add_order_t       in_rec;
  add_order_t       src_rec;
  logic [3:0]       gap_cnt;
  logic             accept;
  logic             load;
  logic [IDX_W-1:0] load_idx;
  logic             last_xfer;

  assign in_rec = '{order_ref:    order_ref,
                    buy_sell:     buy_sell,
                    shares:       shares,
                    stock_symbol: stock_symbol,
                    price:        price};

  assign enc_ready = (state == ST_IDLE);
  assign accept    = enc_ready && enc_valid;

  // Byte 0 is loaded in the handshake cycle, before the holding register
  // has the new record, so the mux reads the live inputs in that cycle.
  assign src_rec = accept ? in_rec : held;

  itch_byte_serializer #(
    .LEN   (MSG_LEN),
    .IDX_W (IDX_W)
  ) u_serializer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (accept),
    .ready_in   (payload_ready_in),
    .valid      (payload_valid_out),
    .start_flag (start_flag_out),
    .end_flag   (end_flag_out),
    .load       (load),
    .load_idx   (load_idx),
    .last_xfer  (last_xfer)
  );

  // Output byte register: refilled on each advance, cleared after the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      payload_out <= 8'h00;
    end else if (load) begin
      payload_out <= add_order_byte(src_rec, load_idx);
    end else if (last_xfer) begin
      payload_out <= 8'h00;
    end
  end

  // Length side-band: raised with byte 0, dropped once byte 0 is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      length_valid_out    <= 1'b0;
      expected_length_out <= 6'd0;
    end else if (accept) begin
      length_valid_out    <= 1'b1;
      expected_length_out <= 6'(MSG_LEN);
    end else if (payload_valid_out && payload_ready_in) begin
      length_valid_out    <= 1'b0;
      expected_length_out <= 6'd0;
    end
  end

  // Control FSM: record capture, send tracking, inter-message gap, counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      held      <= '0;
      gap_cnt   <= 4'd0;
      msg_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enc_valid) begin
            held  <= in_rec;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (last_xfer) begin
            msg_count <= msg_count + 1'b1;
            if (GAP_CYC > 0) begin
              state   <= ST_GAP;
              gap_cnt <= 4'd0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
